// File: rtl/bp_miss_window_ctrl.sv
// Windowed branch/misprediction statistics controller.
// Counts resolved branches, mispredictions and elapsed cycles over a window
// closed by a branch-count or cycle-count limit, then hands a snapshot of the
// totals to a consumer over a valid/ready handshake.
module bp_miss_window_ctrl #(
    parameter int WIDTH      = 16,
    parameter int WINDOW     = 256,
    parameter int MAX_CYCLES = 65535
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             continuous_i,
    input  logic             branch_i,
    input  logic             miss_i,
    output logic             report_valid_o,
    input  logic             report_ready_i,
    output logic [WIDTH-1:0] report_branches_o,
    output logic [WIDTH-1:0] report_misses_o,
    output logic [WIDTH-1:0] report_cycles_o,
    output logic             overrun_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] WIN_LIM = WIDTH'(WINDOW);
    localparam logic [WIDTH-1:0] CYC_LIM = WIDTH'(MAX_CYCLES);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] br_q, br_d, ms_q, ms_d, cyc_q, cyc_d;
    logic [WIDTH-1:0] rep_br_q, rep_br_d, rep_ms_q, rep_ms_d, rep_cyc_q, rep_cyc_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    // Counter values after one counting cycle. A window that already reached a
    // limit is frozen: it keeps its value so the pending snapshot stays exact.
    logic             frozen;
    logic [WIDTH-1:0] br_inc, ms_inc, cyc_inc;
    logic             end_hit;

    // Next-state, counter and report update logic; STOP overrides everything.
    always_comb begin
        state_d   = state_q;
        br_d      = br_q;
        ms_d      = ms_q;
        cyc_d     = cyc_q;
        rep_br_d  = rep_br_q;
        rep_ms_d  = rep_ms_q;
        rep_cyc_d = rep_cyc_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;

        frozen  = (br_q == WIN_LIM) || (cyc_q == CYC_LIM);
        br_inc  = frozen ? br_q  : br_q  + WIDTH'(branch_i);
        ms_inc  = frozen ? ms_q  : ms_q  + WIDTH'(branch_i & miss_i);
        cyc_inc = frozen ? cyc_q : cyc_q + WIDTH'(1'b1);
        end_hit = (br_inc == WIN_LIM) || (cyc_inc == CYC_LIM);

        unique case (state_q)
            S_IDLE: begin
                br_d  = ZERO;
                ms_d  = ZERO;
                cyc_d = ZERO;
                if (start_i) begin
                    state_d = S_RUN;
                    ovr_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (end_hit) begin
                    rep_br_d  = br_inc;
                    rep_ms_d  = ms_inc;
                    rep_cyc_d = cyc_inc;
                    valid_d   = 1'b1;
                    br_d      = ZERO;
                    ms_d      = ZERO;
                    cyc_d     = ZERO;
                    state_d   = S_REPORT;
                end else begin
                    br_d  = br_inc;
                    ms_d  = ms_inc;
                    cyc_d = cyc_inc;
                end
            end
            S_REPORT: begin
                if (valid_q && report_ready_i) begin
                    // Accept wins over counting: live counters are retained.
                    valid_d = 1'b0;
                    if (continuous_i) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                        br_d    = ZERO;
                        ms_d    = ZERO;
                        cyc_d   = ZERO;
                    end
                end else if (continuous_i) begin
                    br_d  = br_inc;
                    ms_d  = ms_inc;
                    cyc_d = cyc_inc;
                    if (end_hit) begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    br_d  = ZERO;
                    ms_d  = ZERO;
                    cyc_d = ZERO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop_i) begin
            state_d   = S_IDLE;
            br_d      = ZERO;
            ms_d      = ZERO;
            cyc_d     = ZERO;
            rep_br_d  = ZERO;
            rep_ms_d  = ZERO;
            rep_cyc_d = ZERO;
            valid_d   = 1'b0;
            ovr_d     = ovr_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            br_q      <= '0;
            ms_q      <= '0;
            cyc_q     <= '0;
            rep_br_q  <= '0;
            rep_ms_q  <= '0;
            rep_cyc_q <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            ms_q      <= ms_d;
            cyc_q     <= cyc_d;
            rep_br_q  <= rep_br_d;
            rep_ms_q  <= rep_ms_d;
            rep_cyc_q <= rep_cyc_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign report_valid_o    = valid_q;
    assign report_branches_o = rep_br_q;
    assign report_misses_o   = rep_ms_q;
    assign report_cycles_o   = rep_cyc_q;
    assign overrun_o         = ovr_q;
    assign busy_o            = (state_q != S_IDLE);
    assign state_o           = state_q;

endmodule

// File: tb/tb_bp_miss_window_ctrl.sv
// Testbench for bp_miss_window_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the window
// rules.
module tb_bp_miss_window_ctrl;

    localparam int W   = 8;
    localparam int WIN = 4;
    localparam int MAXC = 20;

    logic         clk = 1'b0;
    logic         rst_n, start, stop, cont, br, ms, rdy;
    logic         valid, ovr, busy;
    logic [W-1:0] rbr, rms, rcyc;
    logic [1:0]   st;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0 idle, 1 counting, 2 holding a report.
    int m_mode, m_br, m_ms, m_cyc, m_rbr, m_rms, m_rcyc;
    bit m_valid, m_ovr;

    always #5 clk = ~clk;

    bp_miss_window_ctrl #(.WIDTH(W), .WINDOW(WIN), .MAX_CYCLES(MAXC)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .stop_i            (stop),
        .continuous_i      (cont),
        .branch_i          (br),
        .miss_i            (ms),
        .report_valid_o    (valid),
        .report_ready_i    (rdy),
        .report_branches_o (rbr),
        .report_misses_o   (rms),
        .report_cycles_o   (rcyc),
        .overrun_o         (ovr),
        .busy_o            (busy),
        .state_o           (st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit window_full();
        return (m_br >= WIN) || (m_cyc >= MAXC);
    endfunction

    // One clock edge of the window rules applied to the currently driven inputs.
    task automatic model_step();
        int eb, em;
        eb = br ? 1 : 0;
        em = (br && ms) ? 1 : 0;
        if (!rst_n) begin
            m_mode = 0; m_br = 0; m_ms = 0; m_cyc = 0;
            m_rbr = 0; m_rms = 0; m_rcyc = 0; m_valid = 0; m_ovr = 0;
        end else if (stop) begin
            m_mode = 0; m_br = 0; m_ms = 0; m_cyc = 0;
            m_rbr = 0; m_rms = 0; m_rcyc = 0; m_valid = 0;
        end else if (m_mode == 0) begin
            m_br = 0; m_ms = 0; m_cyc = 0;
            if (start) begin
                m_mode = 1;
                m_ovr  = 0;
            end
        end else if (m_mode == 1) begin
            if (!window_full()) begin
                m_br += eb; m_ms += em; m_cyc += 1;
            end
            if (window_full()) begin
                m_rbr = m_br; m_rms = m_ms; m_rcyc = m_cyc;
                m_valid = 1; m_mode = 2;
                m_br = 0; m_ms = 0; m_cyc = 0;
            end
        end else begin
            if (m_valid && rdy) begin
                $display("report accepted: branches=%0d misses=%0d cycles=%0d continuous=%0d",
                         m_rbr, m_rms, m_rcyc, cont);
                m_valid = 0;
                if (cont) m_mode = 1;
                else begin
                    m_mode = 0; m_br = 0; m_ms = 0; m_cyc = 0;
                end
            end else if (cont) begin
                if (!window_full()) begin
                    m_br += eb; m_ms += em; m_cyc += 1;
                    if (window_full()) m_ovr = 1;
                end
            end else begin
                m_br = 0; m_ms = 0; m_cyc = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("state",    st,    m_mode);
        check("busy",     busy,  m_mode != 0);
        check("valid",    valid, m_valid);
        check("branches", rbr,   m_rbr);
        check("misses",   rms,   m_rms);
        check("cycles",   rcyc,  m_rcyc);
        check("overrun",  ovr,   m_ovr);
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare on the falling edge.
    task automatic tick(input logic rn, input logic sa, input logic so, input logic co,
                        input logic b, input logic m, input logic r);
        rst_n = rn; start = sa; stop = so; cont = co; br = b; ms = m; rdy = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 0; start = 0; stop = 0; cont = 0; br = 0; ms = 0; rdy = 0;
        m_mode = 0; m_br = 0; m_ms = 0; m_cyc = 0;
        m_rbr = 0; m_rms = 0; m_rcyc = 0; m_valid = 0; m_ovr = 0;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 1, 1, 1);
        check("reset_state", st, 0);
        check("reset_valid", valid, 0);

        // 1: four branches, misses on the 2nd and 4th, single-shot.
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 1, 1, 0);
        tick(1, 0, 0, 0, 1, 0, 0);
        check("t1_not_yet", valid, 0);
        tick(1, 0, 0, 0, 1, 1, 0);
        check("t1_valid", valid, 1);
        check("t1_br", rbr, 4);
        check("t1_ms", rms, 2);
        check("t1_cyc", rcyc, 4);
        tick(1, 0, 0, 0, 0, 0, 1);
        check("t1_idle", st, 0);
        check("t1_vclr", valid, 0);

        // 2: no branches, the cycle limit closes the window.
        tick(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAXC; i++) tick(1, 0, 0, 0, 0, 1, 0);
        check("t2_valid", valid, 1);
        check("t2_cyc", rcyc, MAXC);
        check("t2_br", rbr, 0);
        check("t2_ms", rms, 0);
        tick(1, 0, 0, 0, 0, 0, 1);

        // 3: continuous, three held cycles then accept; one more branch closes window 2.
        tick(1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) tick(1, 0, 0, 1, 1, 0, 0);
        check("t3_valid1", valid, 1);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, 1, 1, 0);
        tick(1, 0, 0, 1, 0, 0, 1);
        check("t3_run", st, 1);
        tick(1, 0, 0, 1, 1, 0, 0);
        check("t3_valid2", valid, 1);
        check("t3_br2", rbr, WIN);
        check("t3_ovr", ovr, 0);
        tick(1, 0, 1, 1, 0, 0, 0);

        // 4: continuous, long hold overruns; frozen window re-reports right after accept.
        tick(1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) tick(1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 1, 1, 0, 0);
        check("t4_ovr", ovr, 1);
        tick(1, 0, 0, 1, 1, 0, 1);
        check("t4_vlow", valid, 0);
        tick(1, 0, 0, 1, 1, 0, 0);
        check("t4_revalid", valid, 1);
        check("t4_br", rbr, WIN);
        tick(1, 0, 1, 0, 0, 0, 0);
        check("t4_ovr_sticky", ovr, 1);
        tick(1, 1, 0, 0, 0, 0, 0);
        check("t4_ovr_clr", ovr, 0);

        // 5: STOP together with the closing branch.
        for (int i = 0; i < WIN - 1; i++) tick(1, 0, 0, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 1, 1, 0);
        check("t5_idle", st, 0);
        check("t5_valid", valid, 0);
        check("t5_br", rbr, 0);

        // 6: reset in REPORT with READY high; MISS without BRANCH is ignored.
        tick(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < WIN; i++) tick(1, 0, 0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 1);
        check("t6_state", st, 0);
        check("t6_cyc", rcyc, 0);
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < WIN; i++) tick(1, 0, 0, 0, 1, 0, 0);
        check("t6_ms", rms, 0);
        tick(1, 0, 0, 0, 0, 0, 1);

        // Random traffic.
        begin
            logic c;
            c = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 49) == 0) c = ~c;
                tick(($urandom_range(0, 299) != 0),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 59) == 0),
                     c,
                     ($urandom_range(0, 1) == 0),
                     ($urandom_range(0, 1) == 0),
                     ($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_miss_window_ctrl.md
Name: bp_miss_window_ctrl

Overview:
Measurement controller for branch-predictor statistics in the RV32IM pipeline.
- Sequences windowed counting of resolved branches, mispredictions and elapsed cycles.
- Closes a window on a branch-count or cycle-count limit and snapshots the totals into report registers.
- Hands each snapshot to a consumer (debug/CSR logic) over a valid/ready handshake, in single-shot or continuous mode.

Parameters:
WIDTH, 16, width of every counter and report field
WINDOW, 256, branches per window; legal range 1..2^WIDTH-1
MAX_CYCLES, 65535, cycle limit per window; legal range 1..2^WIDTH-1

Ports:
CLOCK  in  1  clock; all state updates on the rising edge
RESET_N  in  1  synchronous, active-low reset
START  in  1  pulse; begins measurement; honoured only in IDLE
STOP  in  1  pulse; aborts to IDLE from any state
CONTINUOUS  in  1  1 = restart the window automatically after each report
BRANCH  in  1  one branch resolved this cycle
MISS  in  1  that branch was mispredicted; ignored when BRANCH=0
REPORT_VALID  out  1  snapshot available
REPORT_READY  in  1  consumer accepts snapshot
REPORT_BRANCHES  out  WIDTH  snapshot branch count
REPORT_MISSES  out  WIDTH  snapshot miss count
REPORT_CYCLES  out  WIDTH  snapshot cycle count
OVERRUN  out  1  sticky; a continuous window filled while the previous report was unaccepted
BUSY  out  1  state != IDLE
STATE  out  2  IDLE=0, RUN=1, REPORT=2

Behaviour:
Reset:
- RESET_N=0 at an edge: state IDLE.
- Live counters, report registers, REPORT_VALID and OVERRUN all 0.
- Reset overrides every other input, including mid-window and mid-handshake.

Live counters (internal, WIDTH bits each):
- Counting cycle: each RUN cycle, and each REPORT cycle when CONTINUOUS=1.
- In a counting cycle: cyc += 1; br += BRANCH; ms += BRANCH&MISS.
- Invariant: ms <= br <= WINDOW.
- No wrap: the limits are reached before all-ones.

IDLE:
- Live counters held at 0; events are dropped.
- START=1 and STOP=0 -> RUN on the next edge.

RUN, window end:
- End condition at an edge: next br == WINDOW, or next cyc == MAX_CYCLES.
- The end-cycle event is included in the snapshot.
- On end:
  - report registers <= next counter values
  - REPORT_VALID <= 1
  - live counters <= 0
  - state -> REPORT
- Latency: REPORT_VALID rises on the edge at which the WINDOW-th branch is sampled.

REPORT:
- Report registers are stable while REPORT_VALID=1.
- CONTINUOUS=0: events are dropped and live counters held at 0.
- CONTINUOUS=1: live counters keep counting the next window.
- If the end condition is met in REPORT:
  - live counters freeze at that value; further events are dropped
  - OVERRUN <= 1
- Accept = REPORT_VALID & REPORT_READY at an edge:
  - REPORT_VALID <= 0
  - CONTINUOUS=1 -> RUN, live counters retained.
  - CONTINUOUS=0 -> IDLE.
  - A frozen, already-full window closes on the first RUN edge: report loaded again, back to REPORT.
- CONTINUOUS is sampled at the accept edge.

Priority and simultaneous events:
- RESET_N > STOP > accept/end-of-window > counting.
- STOP in any state -> IDLE next edge; live counters, report registers and REPORT_VALID cleared. OVERRUN is unaffected.
- START outside IDLE is ignored. START with STOP in IDLE leaves the state IDLE.
- OVERRUN clears only on reset or an honoured START.
- REPORT_READY while REPORT_VALID=0 has no effect.

Outputs are registered; there is no combinational path from any input to any output.

Test Plan:
1. WINDOW=4, CONTINUOUS=0: START; BRANCH on 4 consecutive cycles, MISS on the 2nd and 4th -> REPORT_VALID=1 with BRANCHES=4, MISSES=2, CYCLES=4; READY=1 -> next cycle STATE=IDLE, VALID=0.
2. MAX_CYCLES=20, WINDOW=256, no branches -> after 20 RUN cycles: VALID=1 with CYCLES=20, BRANCHES=0, MISSES=0.
3. CONTINUOUS=1, WINDOW=4: hold READY=0 for 3 cycles after VALID while branching every cycle; then accept -> first report 4/x/4. The second window has already counted 3 REPORT-cycle branches, so one more branch closes it with BRANCHES=4; OVERRUN=0.
4. CONTINUOUS=1, WINDOW=4: hold READY=0 for 10 cycles while branching -> OVERRUN=1 and live br frozen at 4. After accept, VALID re-asserts on the next edge with BRANCHES=4. OVERRUN clears only after STOP then START.
5. STOP asserted the same cycle as the WINDOW-th branch -> STATE=IDLE, VALID=0, report registers 0.
6. RESET_N=0 mid-REPORT with READY=1 -> all outputs 0 next edge. MISS=1 with BRANCH=0 in RUN -> MISSES unchanged.
